instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction-side initiator for the shared von Neumann memory. It drives the memory's instruction address, samples the returned byte, and buffers bytes in a small prefetch FIFO. It assembles 1- or 2-byte instructions and presents them to decode with a valid/ready handshake. It also accepts branch/jump redirects from execute.

Parameters:
ADDR_WIDTH, 8, memory address width; PC wraps modulo 2^ADDR_WIDTH
DATA_WIDTH, 8, memory word width (one instruction byte)
FIFO_DEPTH, 4, prefetch byte FIFO entries; power of two, >= 2
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
mem_addr  out  ADDR_WIDTH  instruction address to memory
mem_data  in  DATA_WIDTH  instruction byte from memory, combinational read of mem_addr
redirect_valid  in  1  redirect request from execute
redirect_pc  in  ADDR_WIDTH  redirect target
out_valid  out  1  complete instruction available
out_ready  in  1  decode accepts instruction
out_instr  out  2*DATA_WIDTH  {byte0, byte1}; byte1 is zero for 1-byte instructions
out_len  out  1  0 = 1-byte, 1 = 2-byte
out_pc  out  ADDR_WIDTH  address of byte0

Behaviour:
- Reset (async, rst=0): fetch_pc=RESET_PC, head_pc=RESET_PC, FIFO count=0, out_valid=0, out_instr=0, out_len=0, out_pc=RESET_PC. mem_addr is held at RESET_PC during reset.
- mem_addr = fetch_pc at all times (combinational from register).
- Fetch: when count < FIFO_DEPTH and redirect_valid=0, the posedge pushes mem_data and sets fetch_pc <= fetch_pc+1 (wraps 0xFF -> 0x00). Otherwise no push and fetch_pc holds.
- Full test uses count before the pop. There is no same-cycle pop bypass: a full FIFO that pops does not fetch in that cycle.
- Length decode: byte0[7:4] == LONG_OPC gives a 2-byte instruction; any other value gives 1 byte.
- out_valid = !redirect_valid && (count>=1 for short || count>=2 for long). out_instr, out_len and out_pc are combinational from the FIFO head and head_pc.
- Pop: when out_valid && out_ready, the posedge removes 1 or 2 bytes and sets head_pc <= head_pc + len (with wrap). Push and pop in the same cycle are legal; count updates by push-pop.
- Outputs are held stable while out_valid=1 and out_ready=0.
- Redirect: redirect_valid=1 has priority over everything. On that posedge:
  - the FIFO is flushed (count=0);
  - fetch_pc <= redirect_pc and head_pc <= redirect_pc;
  - no push and no pop occur, and out_valid is forced 0 in that cycle.
- Latency: the first out_valid comes 1 cycle after the redirect edge for a short instruction, 2 cycles for a long one. The same latency applies after reset release.
- Wrap: a long instruction at 0xFF takes byte1 from 0x00, and out_pc=0xFF.
- Reset mid-operation: immediate return to reset state; any partially buffered instruction is discarded.
- Only one redirect is honoured per cycle; a held redirect_valid re-flushes on every cycle it is high.

Decomposition:
- Shared package fetch_pkg: LONG_OPC (4'hC), length encodings LEN_SHORT/LEN_LONG, and a RESET_PC default constant shared with the memory map.
- Sub-module fetch_byte_fifo contains:
  - circular byte FIFO with wr_en, pop_cnt (0/1/2), flush, count, head and head+1 peek;
  - pointers of $clog2(FIFO_DEPTH) bits, wrapping naturally.
- The top level holds fetch_pc, head_pc, length decode and handshake logic.

Test Plan:
- Reset then release with memory bytes 0x10,0x20,0x30 at 0..2 and out_ready=1. Expected: out_instr 0x1000 @pc0, 0x2000 @pc1, 0x3000 @pc2 on consecutive cycles, first out_valid 1 cycle after release.
- Memory bytes 0xC5,0x7A,0x11 at 0..2. Expected: 0xC57A len=1 pc=0, then 0x1100 len=0 pc=2.
- out_ready=0 for 10 cycles. Expected: mem_addr stops advancing at RESET_PC+FIFO_DEPTH (4), outputs stable. On out_ready=1, in-order drain with no lost bytes.
- Assert redirect_valid with redirect_pc=0x40 while the FIFO holds 3 bytes. Expected: out_valid=0 that cycle, next mem_addr=0x40, next out_pc=0x40, stale bytes never emitted.
- Redirect to 0xFF with 0xC3 at 0xFF and 0x99 at 0x00. Expected: out_instr=0xC399, len=1, pc=0xFF, then out_pc=0x01.
- Pull rst low mid-stream with a long instruction half-buffered. Expected: immediately out_valid=0 and mem_addr=RESET_PC. After release, fetch restarts from RESET_PC with correct instructions.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: long-opcode marker, instruction length encoding
// and the boot address shared with the memory map.
package fetch_pkg;

  localparam logic [3:0]  LONG_OPC         = 4'hC;
  localparam int unsigned RESET_PC_DEFAULT = 0;

  typedef enum logic {
    LEN_SHORT = 1'b0,
    LEN_LONG  = 1'b1
  } len_e;

  function automatic logic [1:0] len_bytes(input len_e len);
    return (len == LEN_LONG) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/fetch_byte_fifo.sv
// Circular prefetch byte FIFO with single-byte push, 0/1/2-byte pop, flush,
// and a two-entry peek at the head for instruction assembly.
module fetch_byte_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          wr_en_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic [1:0]                    pop_cnt_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic [DATA_WIDTH-1:0]         head_o,
  output logic [DATA_WIDTH-1:0]         head_next_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         rd_ptr_nx;
  logic [CW-1:0]         count_q, count_d;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_i) wr_ptr_d = wr_ptr_q + PW'(1);
      rd_ptr_d = rd_ptr_q + PW'(pop_cnt_i);
      count_d  = count_q + CW'(wr_en_i) - CW'(pop_cnt_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_ptr_nx   = rd_ptr_q + PW'(1);
  assign count_o     = count_q;
  assign head_o      = mem_q[rd_ptr_q];
  assign head_next_o = mem_q[rd_ptr_nx];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: streams bytes from memory into a prefetch FIFO, assembles
// 1/2-byte instructions for decode, and restarts on execute redirects.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_instr,
  output logic                    out_len,
  output logic [ADDR_WIDTH-1:0]   out_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] head_byte, next_byte;
  logic [DATA_WIDTH-1:0] byte0, byte1;
  len_e                  len;
  logic                  has_byte0, has_byte1, has_instr;
  logic                  fetch_en, pop_en;
  logic [1:0]            pop_cnt;

  fetch_byte_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .wr_en_i     (fetch_en),
    .wr_data_i   (mem_data),
    .pop_cnt_i   (pop_cnt),
    .count_o     (count),
    .head_o      (head_byte),
    .head_next_o (next_byte)
  );

  assign mem_addr = fetch_pc_q;

  always_comb begin
    has_byte0 = (count != '0);
    has_byte1 = (count >= CW'(2));
    len       = (has_byte0 && head_byte[DATA_WIDTH-1 -: 4] == LONG_OPC) ? LEN_LONG : LEN_SHORT;
    has_instr = (len == LEN_LONG) ? has_byte1 : has_byte0;

    out_valid = !redirect_valid && has_instr;
    pop_en    = out_valid && out_ready;
    pop_cnt   = pop_en ? len_bytes(len) : 2'd0;
    // Full is judged on the pre-pop count: a draining full FIFO still skips this fetch.
    fetch_en  = !redirect_valid && (count < CW'(FIFO_DEPTH));

    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      head_pc_d  = redirect_pc;
    end else begin
      if (fetch_en) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
      if (pop_en)   head_pc_d  = head_pc_q + ADDR_WIDTH'(pop_cnt);
    end

    // Unbuffered bytes read as zero so an empty FIFO presents a clean all-zero instruction.
    byte0     = has_byte0 ? head_byte : '0;
    byte1     = (len == LEN_LONG && has_byte1) ? next_byte : '0;
    out_instr = {byte0, byte1};
    out_len   = (len == LEN_LONG);
    out_pc    = head_pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_ADDR;
      head_pc_q  <= RESET_ADDR;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// ready/redirect/reset traffic, scored against a parse of the memory image.
module tb_instr_fetch_unit;

  localparam logic [7:0] RESET_PC_TB = 8'h00;

  typedef struct packed {
    logic [15:0] instr;
    logic        len;
    logic [7:0]  pc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic        out_len;
  logic [7:0]  out_pc;

  logic [7:0]  mem [256];
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_hs     = 0;

  instr_fetch_unit #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .RESET_PC   (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_len        (out_len),
    .out_pc         (out_pc)
  );

  assign mem_data = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the instruction stream is the memory image parsed from a start address.
  task automatic load_stream(input logic [7:0] start_pc);
    logic [7:0] pc;
    logic [7:0] b0;
    logic       is_long;
    exp_t       e;
    exp_q.delete();
    pc = start_pc;
    for (int i = 0; i < 512; i++) begin
      b0       = mem[pc];
      is_long  = (b0[7:4] == 4'hC);
      e.instr  = {b0, is_long ? mem[8'(pc + 8'd1)] : 8'h00};
      e.len    = is_long;
      e.pc     = pc;
      exp_q.push_back(e);
      pc = is_long ? 8'(pc + 8'd2) : 8'(pc + 8'd1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stream_underflow: got pc 0x%0h, expected no instruction (t=%0t)", out_pc, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("stream {instr,len,pc}", {7'd0, out_instr, out_len, out_pc},
              {7'd0, mon_e.instr, mon_e.len, mon_e.pc});
        n_hs++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    out_ready      = 1'b0;

    // Reset state and three short instructions back to back.
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
    tick(); tick();
    check("reset mem_addr", mem_addr, 32'h00);
    check("reset out_valid", out_valid, 0);
    check("reset out_instr", out_instr, 0);
    check("reset out_len", out_len, 0);
    check("reset out_pc", out_pc, 32'h00);
    out_ready = 1'b1;
    load_stream(RESET_PC_TB);
    rst = 1'b1;
    #1 check("release no valid yet", out_valid, 0);
    tick();
    check("first valid after release", {out_valid, out_pc}, {1'b1, 8'h00});
    tick();
    check("consecutive pc1", {out_valid, out_pc}, {1'b1, 8'h01});
    tick();
    check("consecutive pc2", {out_valid, out_instr}, {1'b1, 16'h3000});

    // Long instruction needs two buffered bytes.
    rst = 1'b0;
    exp_q.delete();
    mem[0] = 8'hC5; mem[1] = 8'h7A; mem[2] = 8'h11;
    tick();
    load_stream(RESET_PC_TB);
    rst = 1'b1;
    tick();
    check("long half buffered", out_valid, 0);
    tick();
    check("long instr", {out_valid, out_len, out_pc, out_instr}, {1'b1, 1'b1, 8'h00, 16'hC57A});
    tick();
    check("short after long", {out_valid, out_len, out_pc, out_instr}, {1'b1, 1'b0, 8'h02, 16'h1100});

    // Backpressure: prefetch stops at depth, head stays put.
    rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b0;
    tick();
    load_stream(RESET_PC_TB);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 1)
        check("stall hold", {out_valid, out_instr, out_pc}, {1'b1, exp_q[0].instr, exp_q[0].pc});
    end
    check("stall mem_addr", mem_addr, 32'h04);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // Redirect while three bytes are buffered.
    rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b0;
    tick();
    load_stream(RESET_PC_TB);
    rst = 1'b1;
    tick(); tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    mem[8'h40] = 8'h05; mem[8'h41] = 8'h06;
    load_stream(8'h40);
    #1 check("redirect kills valid", out_valid, 0);
    tick();
    redirect_valid = 1'b0;
    check("redirect mem_addr", mem_addr, 32'h40);
    check("redirect out_pc", out_pc, 32'h40);
    out_ready = 1'b1;
    tick();
    check("redirect first instr", {out_valid, out_instr, out_pc}, {1'b1, 16'h0500, 8'h40});

    // Long instruction straddling the address wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFF;
    mem[8'hFF] = 8'hC3; mem[8'h00] = 8'h99;
    load_stream(8'hFF);
    tick();
    redirect_valid = 1'b0;
    tick();
    check("wrap half buffered", out_valid, 0);
    tick();
    check("wrap long instr", {out_valid, out_len, out_pc, out_instr}, {1'b1, 1'b1, 8'hFF, 16'hC399});
    tick();
    check("wrap next pc", out_pc, 32'h01);

    // Reset with a long instruction half buffered.
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    mem[8'h80] = 8'hC7; mem[8'h81] = 8'h55;
    load_stream(8'h80);
    tick();
    redirect_valid = 1'b0;
    tick();
    check("midreset long pending", out_valid, 0);
    rst = 1'b0;
    exp_q.delete();
    #1 check("midreset state", {out_valid, mem_addr, out_pc, out_instr}, {1'b0, 8'h00, 8'h00, 16'h0000});
    mem[0] = 8'h21;
    tick();
    load_stream(RESET_PC_TB);
    rst = 1'b1;
    tick();
    check("restart instr", {out_valid, out_instr, out_pc}, {1'b1, 16'h2100, 8'h00});

    // Randomized ready, redirect (sometimes held) and reset traffic.
    n_hs = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int r;
      r = $urandom_range(0, 99);
      out_ready = ($urandom_range(0, 3) != 0);
      if (r < 5 || (redirect_valid && r < 40)) begin
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'($urandom);
        load_stream(redirect_pc);
      end else if (r == 5) begin
        redirect_valid = 1'b0;
        rst            = 1'b0;
        exp_q.delete();
        load_stream(RESET_PC_TB);
      end else begin
        redirect_valid = 1'b0;
        rst            = 1'b1;
      end
      #1;
      if (redirect_valid) check("random redirect kills valid", out_valid, 0);
      tick();
    end
    redirect_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("random traffic made progress", (n_hs > 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
